// File: rtl/axi_mem_responder.sv
// AXI4 subordinate memory model terminating the slave-side AIB bridge master.
// INCR bursts with full-width beats; independent write (AW/W/B) and read
// (AR/R) state machines share one clock and one register-array memory.
module axi_mem_responder #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 4,
  parameter int DEPTH   = 256
) (
  input  logic               clk_wr,
  input  logic               rst_wr,
  input  logic [IDWIDTH-1:0] awid,
  input  logic [AWIDTH-1:0]  awaddr,
  input  logic [7:0]         awlen,
  input  logic               awvalid,
  output logic               awready,
  input  logic [DWIDTH-1:0]  wdata,
  input  logic [DWIDTH/8-1:0] wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [IDWIDTH-1:0] bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  input  logic [IDWIDTH-1:0] arid,
  input  logic [AWIDTH-1:0]  araddr,
  input  logic [7:0]         arlen,
  input  logic               arvalid,
  output logic               arready,
  output logic [IDWIDTH-1:0] rid,
  output logic [DWIDTH-1:0]  rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready
);

  localparam int NB  = DWIDTH / 8;
  localparam int BSH = $clog2(NB);
  localparam int AB  = $clog2(DEPTH);
  // Index adder is wide enough that start + 255 never wraps back into range.
  localparam int IW  = AB + 9;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Low word-index bits of a byte address (the part that addresses memory).
  function automatic logic [AB-1:0] addr_lo(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] word;
    word = a >> BSH;
    return word[AB-1:0];
  endfunction

  // Set when the start word index already lies beyond the memory.
  function automatic logic addr_hi(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] word;
    word = a >> BSH;
    return |(word >> AB);
  endfunction

  function automatic logic [IW-1:0] beat_idx(input logic [AB-1:0] lo, input logic [7:0] beat);
    return IW'(lo) + IW'(beat);
  endfunction

  function automatic logic beat_oor(input logic hi, input logic [IW-1:0] idx);
    return hi | (idx[IW-1:AB] != '0);
  endfunction

  wstate_t             wstate;
  logic [IDWIDTH-1:0]  w_id;
  logic [AB-1:0]       w_lo;
  logic                w_hi;
  logic [7:0]          w_len;
  logic [7:0]          w_beat;
  logic                w_err;
  logic [IW-1:0]       w_idx;
  logic                w_oor;
  logic                w_hs;
  logic                w_bad;

  assign w_idx = beat_idx(w_lo, w_beat);
  assign w_oor = beat_oor(w_hi, w_idx);
  assign w_hs  = wvalid & wready;
  // A beat is bad if it misses memory, ends early, or passes awlen without wlast.
  assign w_bad = w_oor | (wlast ? (w_beat != w_len) : (w_beat == w_len));

  // Write channel FSM: AW capture, W beat accounting, B response.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= 2'b00;
      w_id    <= '0;
      w_lo    <= '0;
      w_hi    <= 1'b0;
      w_len   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_id    <= awid;
            w_lo    <= addr_lo(awaddr);
            w_hi    <= addr_hi(awaddr);
            w_len   <= awlen;
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err | w_bad;
            if (wlast) begin
              bresp  <= (w_err | w_bad) ? 2'b10 : 2'b00;
              bid    <= w_id;
              bvalid <= 1'b1;
              wready <= 1'b0;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled store of in-range write beats; storage is never reset.
  always_ff @(posedge clk_wr) begin
    if (w_hs && !w_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[w_idx[AB-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  rstate_t       rstate;
  logic [AB-1:0] r_lo;
  logic          r_hi;
  logic [7:0]    r_len;
  logic [7:0]    r_beat;
  logic [7:0]    r_next;
  logic [AB-1:0] rd_lo;
  logic          rd_hi;
  logic [7:0]    rd_beat;
  logic [IW-1:0] rd_idx;
  logic          rd_oor;

  assign r_next = r_beat + 8'd1;

  // Address of the beat loaded next: beat 0 of a new AR, else the following beat.
  always_comb begin
    rd_lo   = r_lo;
    rd_hi   = r_hi;
    rd_beat = r_next;
    if (rstate == R_IDLE) begin
      rd_lo   = addr_lo(araddr);
      rd_hi   = addr_hi(araddr);
      rd_beat = '0;
    end
  end

  assign rd_idx = beat_idx(rd_lo, rd_beat);
  assign rd_oor = beat_oor(rd_hi, rd_idx);

  // Read channel FSM; R payload is loaded on handshake so it holds while stalled.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= 2'b00;
      rlast   <= 1'b0;
      r_lo    <= '0;
      r_hi    <= 1'b0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            rid     <= arid;
            r_lo    <= rd_lo;
            r_hi    <= rd_hi;
            r_len   <= arlen;
            r_beat  <= '0;
            rdata   <= rd_oor ? '0 : mem[rd_idx[AB-1:0]];
            rresp   <= rd_oor ? 2'b10 : 2'b00;
            rlast   <= (arlen == 8'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              rresp   <= 2'b00;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              r_beat <= r_next;
              rdata  <= rd_oor ? '0 : mem[rd_idx[AB-1:0]];
              rresp  <= rd_oor ? 2'b10 : 2'b00;
              rlast  <= (r_next == r_len);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 subordinate memory model that terminates the AXI master interface presented by the slave-side AIB bridge. It accepts write and read bursts that have crossed the AIB link, stores data in an internal register array and returns B and R responses. This closes the loop for end-to-end link tests. Write and read channels run independent state machines on one clock.

## Interface

Parameters:
- DWIDTH, 32, data width in bits; power of 2, ≥8
- AWIDTH, 32, address width in bits
- IDWIDTH, 4, transaction ID width
- DEPTH, 256, memory depth in DWIDTH-bit words; power of 2

Ports:
- clk_wr  input  1  single clock for all logic
- rst_wr  input  1  reset, asynchronous, active-high
- awid  input  IDWIDTH  write address ID
- awaddr  input  AWIDTH  write start byte address
- awlen  input  8  write beats minus 1
- awvalid  input  1  AW valid
- awready  output  1  AW ready
- wdata  input  DWIDTH  write data
- wstrb  input  DWIDTH/8  byte enables
- wlast  input  1  last write beat
- wvalid  input  1  W valid
- wready  output  1  W ready
- bid  output  IDWIDTH  response ID (= captured awid)
- bresp  output  2  2'b00 OKAY, 2'b10 SLVERR
- bvalid  output  1  B valid
- bready  input  1  B ready
- arid  input  IDWIDTH  read address ID
- araddr  input  AWIDTH  read start byte address
- arlen  input  8  read beats minus 1
- arvalid  input  1  AR valid
- arready  output  1  AR ready
- rid  output  IDWIDTH  read ID (= captured arid)
- rdata  output  DWIDTH  read data
- rresp  output  2  per-beat response
- rlast  output  1  last read beat
- rvalid  output  1  R valid
- rready  input  1  R ready

## Operation

- Bursts are INCR only, with full-width beats. Size and burst type are not ported.
- Word index = addr >> log2(DWIDTH/8). Low address bits are ignored.
- Beat k accesses word (start_index + k). A beat is out of range when its word index ≥ DEPTH.
- Write FSM has three states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, capture awid/awaddr/awlen, clear the beat counter and error flag, and go to W_DATA.
  - W_DATA: wready=1. On each W handshake:
    - If the beat is in range, write the bytes enabled by wstrb.
    - If the beat is out of range, drop the write and set the error flag.
    - Increment the beat counter.
  - The burst ends on wlast only. If wlast arrives at a beat count ≠ awlen, or no wlast arrives by beat awlen, set the error flag. Keep accepting beats until wlast.
  - On the wlast handshake, go to W_RESP.
  - W_RESP: bvalid=1, bresp=error?2'b10:2'b00. On bready, go to W_IDLE.
- Read FSM has two states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, capture arid/araddr/arlen, clear the beat counter, and go to R_DATA.
  - R_DATA: rvalid=1, rdata=mem[word], rlast=(beat==arlen).
  - Out-of-range beat: rdata=0, rresp=2'b10. Otherwise rresp=2'b00.
  - On each R handshake, increment the beat counter. On the rlast handshake, go to R_IDLE.
- Same-cycle write and read to the same word: the read returns the pre-write contents.
- Memory is not cleared by reset. Its contents are undefined until written.

## Timing

- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, arready=0, rvalid=0, rid=0, rdata=0, rresp=0, rlast=0.
- In the first cycle after reset deasserts, both FSMs are idle, so awready=1 and arready=1.
- All outputs are registered or decoded from state; no input reaches an output combinationally.
- AW handshake at cycle N → wready=1 at N+1.
- wlast handshake at N → bvalid=1 at N+1.
- bready at M → awready=1 at M+1.
- AR handshake at N → rvalid=1 with beat 0 data at N+1.
- R delivers one beat per cycle while rready=1. rdata, rresp and rlast are held stable while rvalid=1 and rready=0.
- After the rlast handshake at M, arready=1 at M+1. Bursts do not overlap within a channel.
- Beat counters are 8 bits (max awlen/arlen 255). The word-index adder is log2(DEPTH)+9 bits wide, so range detection never wraps.
- Reset asserted mid-burst: both FSMs return to idle immediately and outputs take their reset values. Writes from beats already accepted remain in memory.

## Test plan

- Single write then read: AW addr=0x10, len=0, wdata=0xDEADBEEF, wstrb=4'hF, then AR addr=0x10, len=0 → bresp=00, bid=awid; rdata=0xDEADBEEF, rlast=1, rvalid exactly 1 cycle after AR handshake.
- 4-beat INCR: write 0x1..0x4 at addr 0x100, then read len=3 with rready toggling 1,0,1,0 → beats 0x1..0x4 in order, data held while stalled, rlast only on beat 3.
- Strobe merge: write 0xFFFFFFFF to word 5, then 0x00000000 with wstrb=4'b0101 → read returns 0xFF00FF00.
- Out of range (DEPTH=256): write len=1 at word 255 → word 255 written, word 256 dropped, bresp=10; read len=1 at word 255 → beat0 rresp=00, beat1 rdata=0, rresp=10.
- Protocol error and reset: awlen=3 with wlast on beat 1 → bresp=10 after beat 1. Then start a 4-beat read and assert rst_wr after beat 1 → rvalid=0 immediately, arready=1 the cycle after release.
- Concurrency: AW and AR accepted in the same cycle for the same word → read returns the old value, write completes with OKAY, and the two channels' timing is independent.
